// File: rtl/rob_seq_ctrl_pkg.sv
// Shared types and default geometry for the ROB sequencer and its bus.
// Default widths match the cir_q instance this block normally drives.
package rob_seq_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } rob_state_e;

  localparam int ROB_Q_OFFSET = 5;
  localparam int ROB_Q_INDEX  = 3;
  localparam int ROB_NUM_FU   = 4;
  localparam int ROB_ENTRY_W  = 2 ** ROB_Q_OFFSET;
  localparam int ROB_ENTRIES  = 2 ** ROB_Q_INDEX;

endpackage

// File: rtl/rob_seq_ctrl_if.sv
// Bus between the ROB sequencer and its surroundings: dispatch, FU completions, cir_q and retire.
// The slave modport is the sequencer side; master is the environment (dispatch/FUs/cir_q).
interface rob_seq_ctrl_if
  import rob_seq_ctrl_pkg::*;
#(
  parameter int Q_OFFSET = ROB_Q_OFFSET,
  parameter int Q_INDEX  = ROB_Q_INDEX,
  parameter int NUM_FU   = ROB_NUM_FU
);
  localparam int W = 2 ** Q_OFFSET;

  logic                      dispatch_valid;
  logic [W-1:0]              dispatch_data;
  logic                      dispatch_ready;
  logic [Q_INDEX-1:0]        dispatch_tag;

  logic [NUM_FU-1:0]         fu_req;
  logic [NUM_FU*Q_INDEX-1:0] fu_idx;
  logic [NUM_FU*W-1:0]       fu_data;
  logic [NUM_FU-1:0]         fu_gnt;

  logic                      flush;

  logic                      q_issue;
  logic                      q_commit;
  logic                      q_update;
  logic [Q_INDEX-1:0]        q_update_index;
  logic [W-1:0]              q_datain_issue;
  logic [W-1:0]              q_datain_update;
  logic [W-1:0]              q_dataout_commit;
  logic                      q_full;
  logic                      q_empty;

  logic                      commit_valid;
  logic [W-1:0]              commit_data;
  logic                      busy_flush;

  modport slave (
    input  dispatch_valid, dispatch_data, fu_req, fu_idx, fu_data, flush,
           q_dataout_commit, q_full, q_empty,
    output dispatch_ready, dispatch_tag, fu_gnt, q_issue, q_commit, q_update,
           q_update_index, q_datain_issue, q_datain_update,
           commit_valid, commit_data, busy_flush
  );

  modport master (
    output dispatch_valid, dispatch_data, fu_req, fu_idx, fu_data, flush,
           q_dataout_commit, q_full, q_empty,
    input  dispatch_ready, dispatch_tag, fu_gnt, q_issue, q_commit, q_update,
           q_update_index, q_datain_issue, q_datain_update,
           commit_valid, commit_data, busy_flush
  );

endinterface

// File: rtl/rob_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer in the same cycle,
// then moves the pointer just past the winner. The pointer holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;

  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    ptr_nxt = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/rob_seq_ctrl.sv
// ROB sequencer: issues dispatched entries into cir_q, arbitrates FU completions onto its
// update port, retires the head once done, and drains the queue on flush.
module rob_seq_ctrl
  import rob_seq_ctrl_pkg::*;
#(
  parameter int Q_OFFSET = ROB_Q_OFFSET,
  parameter int Q_INDEX  = ROB_Q_INDEX,
  parameter int NUM_FU   = ROB_NUM_FU
) (
  input  logic           clk,
  input  logic           rst,
  rob_seq_ctrl_if.slave  bus
);
  localparam int W = 2 ** Q_OFFSET;
  localparam int E = 2 ** Q_INDEX;
  localparam logic [Q_INDEX-1:0] ONE = Q_INDEX'(1);

  rob_state_e         state_q;
  logic [Q_INDEX-1:0] head_q;
  logic [Q_INDEX-1:0] tail_q;
  logic [E-1:0]       done_q;

  logic               run;
  logic               drain;
  logic [NUM_FU-1:0]  arb_req;
  logic [NUM_FU-1:0]  gnt;
  logic               any_gnt;
  logic [Q_INDEX-1:0] upd_idx;
  logic [W-1:0]       upd_data;
  logic               ready;
  logic               issue;
  logic               commit_ok;
  logic               commit;
  logic               drain_done;

  assign run   = (state_q == RUN);
  assign drain = (state_q == DRAIN);

  // Grants are suppressed outside RUN and in the flush cycle, so the pointer freezes too.
  assign arb_req = bus.fu_req & {NUM_FU{run & ~bus.flush}};

  rr_arbiter #(.N(NUM_FU)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .gnt (gnt)
  );

  assign any_gnt = |gnt;

  always_comb begin
    upd_idx  = '0;
    upd_data = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        upd_idx  = bus.fu_idx[i*Q_INDEX +: Q_INDEX];
        upd_data = bus.fu_data[i*W +: W];
      end
    end
  end

  // cir_q has a single write port, so any pending completion request blocks dispatch.
  assign ready     = run & ~bus.flush & ~bus.q_full & ~|bus.fu_req;
  assign issue     = bus.dispatch_valid & ready;
  assign commit_ok = run & ~bus.flush & ~bus.q_empty & done_q[head_q];
  assign commit    = commit_ok | (drain & ~bus.q_empty);

  // Leave DRAIN together with the last drained entry so no idle busy cycle follows.
  assign drain_done = bus.q_empty | ((head_q + ONE) == tail_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      done_q  <= '0;
    end else begin
      if (issue) begin
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + ONE;
      end
      if (commit_ok) begin
        done_q[head_q] <= 1'b0;
      end
      if (commit) begin
        head_q <= head_q + ONE;
      end
      if (any_gnt) begin
        done_q[upd_idx] <= 1'b1;
      end
      case (state_q)
        RUN: begin
          if (bus.flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= RUN;
            done_q  <= '0;
            tail_q  <= bus.q_empty ? head_q : head_q + ONE;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.dispatch_ready  = ready;
  assign bus.dispatch_tag    = tail_q;
  assign bus.fu_gnt          = gnt;
  assign bus.q_issue         = issue;
  assign bus.q_commit        = commit;
  assign bus.q_update        = any_gnt;
  assign bus.q_update_index  = upd_idx;
  assign bus.q_datain_issue  = bus.dispatch_data;
  assign bus.q_datain_update = upd_data;
  assign bus.commit_valid    = commit_ok;
  assign bus.commit_data     = commit_ok ? bus.q_dataout_commit : '0;
  assign bus.busy_flush      = drain;

endmodule

// File: tb/tb_rob_seq_ctrl.sv
// Directed bench for rob_seq_ctrl with a small behavioural cir_q standing in for the real queue.
module tb_rob_seq_ctrl;
  import rob_seq_ctrl_pkg::*;

  localparam int QO = 5;
  localparam int QI = 3;
  localparam int NF = 4;
  localparam int W  = 32;
  localparam int NE = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rob_seq_ctrl_if #(.Q_OFFSET(QO), .Q_INDEX(QI), .NUM_FU(NF)) bus ();

  rob_seq_ctrl #(.Q_OFFSET(QO), .Q_INDEX(QI), .NUM_FU(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural cir_q: storage, head/tail and occupancy driven by the sequencer's controls.
  logic [W-1:0]  mem [NE];
  logic [QI-1:0] mh;
  logic [QI-1:0] mt;
  int            mcount;

  assign bus.q_full           = (mcount == NE);
  assign bus.q_empty          = (mcount == 0);
  assign bus.q_dataout_commit = mem[mh];

  always @(posedge clk) begin
    if (rst) begin
      mh     <= '0;
      mt     <= '0;
      mcount <= 0;
    end else begin
      if (bus.q_issue) begin
        mem[mt] <= bus.q_datain_issue;
        mt      <= mt + 3'd1;
      end
      if (bus.q_update) mem[bus.q_update_index] <= bus.q_datain_update;
      if (bus.q_commit) mh <= mh + 3'd1;
      mcount <= mcount + int'(bus.q_issue) - int'(bus.q_commit);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.dispatch_valid = 1'b0;
    bus.dispatch_data  = '0;
    bus.fu_req         = '0;
    bus.fu_idx         = '0;
    bus.fu_data        = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      bus.dispatch_valid = 1'b1;
      bus.dispatch_data  = 32'hA000_0000 + i;
      step();
    end
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    if (bus.dispatch_ready !== 1'b1) begin $display("FAIL reset_ready got %0h exp 1", bus.dispatch_ready); errors++; end checks++;
    if (bus.dispatch_tag !== 3'd0) begin $display("FAIL reset_tag got %0d exp 0", bus.dispatch_tag); errors++; end checks++;
    if (bus.fu_gnt !== 4'b0000) begin $display("FAIL reset_gnt got %b exp 0000", bus.fu_gnt); errors++; end checks++;
    if (bus.q_commit !== 1'b0) begin $display("FAIL reset_q_commit got %0h exp 0", bus.q_commit); errors++; end checks++;
    if (bus.q_update !== 1'b0) begin $display("FAIL reset_q_update got %0h exp 0", bus.q_update); errors++; end checks++;
    if (bus.commit_valid !== 1'b0) begin $display("FAIL reset_commit_valid got %0h exp 0", bus.commit_valid); errors++; end checks++;
    if (bus.busy_flush !== 1'b0) begin $display("FAIL reset_busy got %0h exp 0", bus.busy_flush); errors++; end checks++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < NE; i++) begin
      bus.dispatch_valid = 1'b1;
      bus.dispatch_data  = 32'hA000_0000 + i;
      sample();
      if (bus.q_issue !== 1'b1) begin $display("FAIL fill_issue[%0d] got %0h exp 1", i, bus.q_issue); errors++; end checks++;
      if (bus.dispatch_tag !== 3'(i)) begin $display("FAIL fill_tag[%0d] got %0d exp %0d", i, bus.dispatch_tag, i); errors++; end checks++;
      step();
    end
    sample();
    if (bus.dispatch_ready !== 1'b0) begin $display("FAIL fill_full_ready got %0h exp 0", bus.dispatch_ready); errors++; end checks++;
    if (bus.q_issue !== 1'b0) begin $display("FAIL fill_full_issue got %0h exp 0", bus.q_issue); errors++; end checks++;
    step();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_gnt [4];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100; exp_gnt[3] = 4'b1000;
    do_reset();
    bus.fu_req  = 4'b1111;
    bus.fu_idx  = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.fu_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    for (int k = 0; k < 4; k++) begin
      sample();
      if (bus.fu_gnt !== exp_gnt[k]) begin $display("FAIL arb_gnt[%0d] got %b exp %b", k, bus.fu_gnt, exp_gnt[k]); errors++; end checks++;
      if (bus.q_update !== 1'b1) begin $display("FAIL arb_update[%0d] got %0h exp 1", k, bus.q_update); errors++; end checks++;
      if (bus.q_update_index !== 3'(k)) begin $display("FAIL arb_index[%0d] got %0d exp %0d", k, bus.q_update_index, k); errors++; end checks++;
      if (bus.dispatch_ready !== 1'b0) begin $display("FAIL arb_ready[%0d] got %0h exp 0", k, bus.dispatch_ready); errors++; end checks++;
      step();
    end
    bus.fu_req = '0;
  endtask

  task automatic test_commit_order();
    do_reset();
    fill(2);
    bus.fu_req = 4'b0001; bus.fu_idx = 12'd1; bus.fu_data = 128'h5151;
    sample();
    if (bus.fu_gnt !== 4'b0001) begin $display("FAIL order_gnt_idx1 got %b exp 0001", bus.fu_gnt); errors++; end checks++;
    if (bus.commit_valid !== 1'b0) begin $display("FAIL order_no_commit_a got %0h exp 0", bus.commit_valid); errors++; end checks++;
    step();
    bus.fu_idx = 12'd0; bus.fu_data = 128'h5050;
    sample();
    if (bus.fu_gnt !== 4'b0001) begin $display("FAIL order_gnt_idx0 got %b exp 0001", bus.fu_gnt); errors++; end checks++;
    if (bus.commit_valid !== 1'b0) begin $display("FAIL order_no_commit_b got %0h exp 0", bus.commit_valid); errors++; end checks++;
    step();
    bus.fu_req = '0;
    sample();
    if (bus.commit_valid !== 1'b1) begin $display("FAIL order_commit0_valid got %0h exp 1", bus.commit_valid); errors++; end checks++;
    if (bus.commit_data !== 32'h5050) begin $display("FAIL order_commit0_data got %0h exp 5050", bus.commit_data); errors++; end checks++;
    step();
    sample();
    if (bus.commit_valid !== 1'b1) begin $display("FAIL order_commit1_valid got %0h exp 1", bus.commit_valid); errors++; end checks++;
    if (bus.commit_data !== 32'h5151) begin $display("FAIL order_commit1_data got %0h exp 5151", bus.commit_data); errors++; end checks++;
    step();
    sample();
    if (bus.commit_valid !== 1'b0) begin $display("FAIL order_empty_valid got %0h exp 0", bus.commit_valid); errors++; end checks++;
    step();
  endtask

  task automatic test_full_commit();
    do_reset();
    fill(NE);
    bus.fu_req = 4'b0100; bus.fu_idx = 12'd0; bus.fu_data = {32'd0, 32'hCAFE, 64'd0};
    sample();
    if (bus.fu_gnt !== 4'b0100) begin $display("FAIL full_gnt got %b exp 0100", bus.fu_gnt); errors++; end checks++;
    step();
    bus.fu_req = '0;
    bus.dispatch_valid = 1'b1; bus.dispatch_data = 32'hBEEF;
    sample();
    if (bus.commit_valid !== 1'b1) begin $display("FAIL full_commit_valid got %0h exp 1", bus.commit_valid); errors++; end checks++;
    if (bus.commit_data !== 32'hCAFE) begin $display("FAIL full_commit_data got %0h exp cafe", bus.commit_data); errors++; end checks++;
    if (bus.dispatch_ready !== 1'b0) begin $display("FAIL full_same_cycle_ready got %0h exp 0", bus.dispatch_ready); errors++; end checks++;
    step();
    sample();
    if (bus.dispatch_ready !== 1'b1) begin $display("FAIL full_next_ready got %0h exp 1", bus.dispatch_ready); errors++; end checks++;
    if (bus.dispatch_tag !== 3'd0) begin $display("FAIL full_wrap_tag got %0d exp 0", bus.dispatch_tag); errors++; end checks++;
    if (bus.q_issue !== 1'b1) begin $display("FAIL full_wrap_issue got %0h exp 1", bus.q_issue); errors++; end checks++;
    step();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    fill(5);
    bus.fu_req = 4'b0001; bus.fu_idx = 12'd0; bus.fu_data = 128'h77;
    step();
    bus.fu_req = '0;
    bus.flush  = 1'b1;
    sample();
    if (bus.commit_valid !== 1'b0) begin $display("FAIL flush_cycle_commit_valid got %0h exp 0", bus.commit_valid); errors++; end checks++;
    if (bus.q_commit !== 1'b0) begin $display("FAIL flush_cycle_q_commit got %0h exp 0", bus.q_commit); errors++; end checks++;
    if (bus.busy_flush !== 1'b0) begin $display("FAIL flush_cycle_busy got %0h exp 0", bus.busy_flush); errors++; end checks++;
    step();
    bus.flush  = 1'b0;
    bus.fu_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sample();
      if (bus.busy_flush !== 1'b1) begin $display("FAIL drain_busy[%0d] got %0h exp 1", k, bus.busy_flush); errors++; end checks++;
      if (bus.q_commit !== 1'b1) begin $display("FAIL drain_q_commit[%0d] got %0h exp 1", k, bus.q_commit); errors++; end checks++;
      if (bus.commit_valid !== 1'b0) begin $display("FAIL drain_commit_valid[%0d] got %0h exp 0", k, bus.commit_valid); errors++; end checks++;
      if (bus.fu_gnt !== 4'b0000) begin $display("FAIL drain_gnt[%0d] got %b exp 0000", k, bus.fu_gnt); errors++; end checks++;
      if (bus.dispatch_ready !== 1'b0) begin $display("FAIL drain_ready[%0d] got %0h exp 0", k, bus.dispatch_ready); errors++; end checks++;
      step();
    end
    bus.fu_req = '0;
    sample();
    if (bus.busy_flush !== 1'b0) begin $display("FAIL drain_exit_busy got %0h exp 0", bus.busy_flush); errors++; end checks++;
    if (bus.q_commit !== 1'b0) begin $display("FAIL drain_exit_q_commit got %0h exp 0", bus.q_commit); errors++; end checks++;
    if (bus.dispatch_tag !== 3'd5) begin $display("FAIL drain_exit_tag got %0d exp 5", bus.dispatch_tag); errors++; end checks++;
    if (bus.dispatch_ready !== 1'b1) begin $display("FAIL drain_exit_ready got %0h exp 1", bus.dispatch_ready); errors++; end checks++;
    step();
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    fill(5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    sample();
    if (bus.busy_flush !== 1'b1) begin $display("FAIL rstdrain_busy got %0h exp 1", bus.busy_flush); errors++; end checks++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    if (bus.busy_flush !== 1'b0) begin $display("FAIL rstdrain_busy_after got %0h exp 0", bus.busy_flush); errors++; end checks++;
    if (bus.q_commit !== 1'b0) begin $display("FAIL rstdrain_q_commit got %0h exp 0", bus.q_commit); errors++; end checks++;
    if (bus.dispatch_tag !== 3'd0) begin $display("FAIL rstdrain_tag got %0d exp 0", bus.dispatch_tag); errors++; end checks++;
    if (bus.dispatch_ready !== 1'b1) begin $display("FAIL rstdrain_ready got %0h exp 1", bus.dispatch_ready); errors++; end checks++;
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fill();
    test_arbitration();
    test_commit_order();
    test_full_commit();
    test_flush();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
